// File: rtl/regfile_param_pkg.sv
// Shared defaults for the register file so the CPU datapath and decoder agree
// on word width, depth, address width and the hardwired-zero address.
package regfile_param_pkg;

  localparam int WORD_W    = 32;
  localparam int RF_DEPTH  = 32;
  localparam int RF_ADDR_W = 5;
  localparam int ZERO_ADDR = 0;

endpackage

// File: rtl/regfile_param_register_ar.sv
// One storage word: posedge-clocked, asynchronously cleared, load-enabled.
module register_ar #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_o <= '0;
    end else if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/regfile_param.sv
// One-write / two-read register file with optional hardwired zero word,
// optional write-to-read forwarding and an optional registered read stage.
module regfile_param
  import regfile_param_pkg::*;
#(
  parameter int WIDTH        = WORD_W,
  parameter int DEPTH        = RF_DEPTH,
  parameter int ADDR_W       = RF_ADDR_W,
  parameter int ZERO_REG     = 1,
  parameter int BYPASS       = 1,
  parameter int READ_LATENCY = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr1,
  output logic [WIDTH-1:0]  rd_data1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [WIDTH-1:0]  rd_data2
);

  logic             wrOk;
  logic [WIDTH-1:0] word_q [DEPTH];
  logic [WIDTH-1:0] rdVal1;
  logic [WIDTH-1:0] rdVal2;

  // A write counts only when in range and not aimed at a hardwired zero word.
  assign wrOk = wr_en && (int'(wr_addr) < DEPTH) &&
                !((ZERO_REG != 0) && (int'(wr_addr) == ZERO_ADDR));

  for (genvar g = 0; g < DEPTH; g++) begin : gWord
    if ((ZERO_REG != 0) && (g == ZERO_ADDR)) begin : gZero
      assign word_q[g] = '0;
    end else begin : gReg
      register_ar #(.WIDTH(WIDTH)) uWord (
        .clk  (clk),
        .rst_n(rst_n),
        .en_i (wrOk && (int'(wr_addr) == g)),
        .d_i  (wr_data),
        .q_o  (word_q[g])
      );
    end
  end

  always_comb begin
    rdVal1 = '0;
    if ((int'(rd_addr1) < DEPTH) &&
        !((ZERO_REG != 0) && (int'(rd_addr1) == ZERO_ADDR))) begin
      if ((BYPASS != 0) && wrOk && (rd_addr1 == wr_addr)) begin
        rdVal1 = wr_data;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (int'(rd_addr1) == i) rdVal1 = word_q[i];
        end
      end
    end
  end

  always_comb begin
    rdVal2 = '0;
    if ((int'(rd_addr2) < DEPTH) &&
        !((ZERO_REG != 0) && (int'(rd_addr2) == ZERO_ADDR))) begin
      if ((BYPASS != 0) && wrOk && (rd_addr2 == wr_addr)) begin
        rdVal2 = wr_data;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (int'(rd_addr2) == i) rdVal2 = word_q[i];
        end
      end
    end
  end

  // Registered reads sample v(addr) before the edge, so without forwarding
  // a read of the word being written returns its old contents.
  if (READ_LATENCY != 0) begin : gRdReg
    logic [WIDTH-1:0] rdData1_q;
    logic [WIDTH-1:0] rdData2_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rdData1_q <= '0;
        rdData2_q <= '0;
      end else begin
        rdData1_q <= rdVal1;
        rdData2_q <= rdVal2;
      end
    end

    assign rd_data1 = rdData1_q;
    assign rd_data2 = rdData2_q;
  end else begin : gRdComb
    assign rd_data1 = rdVal1;
    assign rd_data2 = rdVal2;
  end

endmodule
